// File: rtl/sw_scan_driver_if.sv
// -----------------------------------------------------------------------------
// sw_scan_driver_if
// Purpose : bundles the switch input and the multiplexed 7-seg drive signals
//           between the board-level switch logic and sw_scan_driver.
// Signals :
//   SW    [12:0]  binary value to show, 0..8191 (driven by master)
//   posb  [3:0]   one-cold digit select, bit i low = digit i lit (driven by slave)
//   num   [3:0]   code to display, 0..9 = digit, 10 = blank (driven by slave)
//   dp            decimal point for the selected digit (driven by slave)
// Protocol: there is no valid/ready handshake. SW is sampled level-style on
//           every clock, and posb/num/dp are free-running registered outputs
//           that are always meaningful once reset is released.
// -----------------------------------------------------------------------------
interface sw_scan_driver_if;
    logic [12:0] SW;
    logic [3:0]  posb;
    logic [3:0]  num;
    logic        dp;

    // Switch side / board top.
    modport master (output SW, input posb, input num, input dp);
    // Display driver side.
    modport slave  (input SW, output posb, output num, output dp);
endinterface

// File: rtl/sw_scan_driver.sv
// -----------------------------------------------------------------------------
// sw_scan_driver
// Purpose : shows a 13-bit binary switch value as 4 decimal digits on a
//           multiplexed 7-seg display. A sequential shift-add-3 converter
//           (one bit per clock) feeds a digit bank with leading-zero blanking,
//           and a scan counter walks the digit select.
// Parameters:
//   SCAN_DIV  clocks each digit stays selected (>= 2)
//   DP_MASK   dp value per digit position, bit i = digit i (0 = ones)
// Ports:
//   CLK          system clock, all logic on posedge
//   RST_N        asynchronous active-low reset
//   bus          slave modport: SW in, posb/num/dp out
//   o_dbg_state  converter FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
module sw_scan_driver #(
    parameter int unsigned SCAN_DIV = 6,
    parameter logic [3:0]  DP_MASK  = 4'b0000
) (
    input  logic              CLK,
    input  logic              RST_N,
    sw_scan_driver_if.slave   bus,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [3:0] BLANK = 4'd10;
    localparam int unsigned CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

    state_t          r_state;
    state_t          w_next;

    logic [12:0]     r_last_sw;
    logic [12:0]     r_bin;
    logic [15:0]     r_bcd;
    logic [3:0]      r_bit_cnt;
    logic [3:0][3:0] r_bank;

    logic            w_sw_changed;
    logic            w_load;
    logic            w_shift;
    logic            w_write;
    logic [15:0]     w_bcd_adj;
    logic [3:0][3:0] w_bank_new;
    // Inputs are at most 8191, so the adjusted thousands nibble never reaches
    // 8 and its MSB is always shifted out as zero.
    logic            w_unused_msb;

    logic [CW-1:0]   r_scan_cnt;
    logic [1:0]      r_pos;
    logic [3:0]      r_posb;
    logic [3:0]      r_num;
    logic            r_dp;

    assign w_sw_changed = (bus.SW != r_last_sw);
    assign o_dbg_state  = r_state;
    assign w_unused_msb = w_bcd_adj[15];

    // ---------------- converter FSM: state register ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ---------------- converter FSM: next state ----------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (w_sw_changed) w_next = ST_SHIFT;
            // r_bit_cnt == 1 means this edge performs the 13th shift.
            ST_SHIFT: if (r_bit_cnt == 4'd1) w_next = ST_DONE;
            ST_DONE:  w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    // ---------------- converter FSM: outputs ----------------
    always_comb begin
        w_load  = 1'b0;
        w_shift = 1'b0;
        w_write = 1'b0;
        case (r_state)
            ST_IDLE:  w_load  = w_sw_changed;
            ST_SHIFT: w_shift = 1'b1;
            ST_DONE:  w_write = 1'b1;
            default:  ;
        endcase
    end

    // Add 3 to every BCD nibble >= 5 before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_bcd_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Leading-zero blanking: a digit is blank when it and every digit above
    // it are zero. The ones digit always shows.
    always_comb begin
        w_bank_new[0] = r_bcd[3:0];
        w_bank_new[1] = (r_bcd[15:4]  == 12'd0) ? BLANK : r_bcd[7:4];
        w_bank_new[2] = (r_bcd[15:8]  == 8'd0)  ? BLANK : r_bcd[11:8];
        w_bank_new[3] = (r_bcd[15:12] == 4'd0)  ? BLANK : r_bcd[15:12];
    end

    // ---------------- converter datapath and digit bank ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_last_sw <= 13'd0;
            r_bin     <= 13'd0;
            r_bcd     <= 16'd0;
            r_bit_cnt <= 4'd0;
            r_bank    <= {BLANK, BLANK, BLANK, 4'd0};
        end else begin
            if (w_load) begin
                r_bin     <= bus.SW;
                r_last_sw <= bus.SW;
                r_bcd     <= 16'd0;
                r_bit_cnt <= 4'd13;
            end else if (w_shift) begin
                {r_bcd, r_bin} <= {w_bcd_adj[14:0], r_bin, 1'b0};
                r_bit_cnt      <= r_bit_cnt - 4'd1;
            end
            // All four digits land on one edge so the display never sees a
            // partially converted value.
            if (w_write) begin
                r_bank <= w_bank_new;
            end
        end
    end

    // ---------------- digit scan ----------------
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_scan_cnt <= '0;
            r_pos      <= 2'd0;
        end else if (r_scan_cnt == CNT_LAST) begin
            r_scan_cnt <= '0;
            r_pos      <= r_pos + 2'd1;
        end else begin
            r_scan_cnt <= r_scan_cnt + 1'b1;
        end
    end

    // Display outputs are registered together from pos so posb, num and dp
    // switch on the same edge, one clock after pos.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_posb <= 4'b1111;
            r_num  <= BLANK;
            r_dp   <= 1'b0;
        end else begin
            r_posb <= ~(4'b0001 << r_pos);
            r_num  <= r_bank[r_pos];
            r_dp   <= DP_MASK[r_pos];
        end
    end

    assign bus.posb = r_posb;
    assign bus.num  = r_num;
    assign bus.dp   = r_dp;

endmodule
